// File: rtl/if0_pkg.sv
// -----------------------------------------------------------------------------
// if0_pkg
// Shared types and constants for the IF0 fetch-PC generator.
//   if0_state_e  : fetch sequencing state (normal / delay-slot pending)
//   IF0_RESET_PC : default boot / flush PC
//   INST_BYTES   : bytes per instruction slot
// -----------------------------------------------------------------------------
package if0_pkg;

    typedef enum logic [0:0] {
        IF0_NORMAL     = 1'b0,
        IF0_DS_PENDING = 1'b1
    } if0_state_e;

    localparam logic [31:0] IF0_RESET_PC = 32'hBFC00000;
    localparam int unsigned INST_BYTES   = 4;

endpackage

// File: rtl/if0_first_taken.sv
// -----------------------------------------------------------------------------
// if0_first_taken
// Combinational priority encoder: finds the lowest slot at or above the fetch
// offset whose NLP entry is both valid and predicted taken.
//   valid [FETCH_WIDTH] : per-slot NLP hit
//   taken [FETCH_WIDTH] : per-slot NLP taken
//   off   [SLOT_BITS]   : first live slot of the current fetch group
//   hit                 : some live slot is predicted taken
//   k     [SLOT_BITS]   : index of that slot (0 when hit is low)
// -----------------------------------------------------------------------------
module if0_first_taken #(
    parameter int unsigned FETCH_WIDTH = 2,
    localparam int unsigned SLOT_BITS  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic [FETCH_WIDTH-1:0] valid,
    input  logic [FETCH_WIDTH-1:0] taken,
    input  logic [SLOT_BITS-1:0]   off,
    output logic                   hit,
    output logic [SLOT_BITS-1:0]   k
);

    // Scan high to low so the lowest qualifying slot is the last one written.
    always_comb begin
        hit = 1'b0;
        k   = '0;
        for (int i = int'(FETCH_WIDTH) - 1; i >= 0; i--) begin
            if (valid[i] && taken[i] && (i >= int'(off))) begin
                hit = 1'b1;
                k   = SLOT_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/if0_pc_gen.sv
// -----------------------------------------------------------------------------
// if0_pc_gen
// IF0 fetch-PC generator for a FETCH_WIDTH-wide fetch group. Selects the next
// fetch PC from backend redirect, IF3 redirect, pending delay-slot target, NLP
// taken prediction or the next sequential aligned group, in that priority.
// A taken branch in the last slot of a group needs its delay slot fetched
// first, so the target is parked in ds_target and a one-slot fetch of the next
// group is issued before jumping.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   flush_i                  : reload RESET_PC
//   pause_i                  : hold PC and state
//   bk_redirect_valid_i/pc_i : backend redirect
//   bk_ready_o               : backend redirect accept (always 1)
//   if3_redirect_i/pc_i      : IF3 predecode redirect
//   nlp_valid_i/taken_i      : per-slot NLP hit / taken
//   nlp_target_i             : per-slot targets, slot k at [32k+31:32k]
//   pc_o                     : current fetch PC (registered)
//   npc_o                    : next sequential aligned group address
//   fetch_mask_o             : valid slots of the current fetch
//   ds_only_o                : current fetch is a delay-slot-only fetch
//
// Optional feature, macro IF0_PERF_CNT_EN:
//   redirect_cnt_o  : saturating count of accepted backend/IF3 redirects
//   ds_bubble_cnt_o : saturating count of delay-slot target jumps
//   Both clear on rst only.
// -----------------------------------------------------------------------------
module if0_pc_gen
    import if0_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = IF0_RESET_PC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      pause_i,
    input  logic                      bk_redirect_valid_i,
    input  logic [31:0]               bk_redirect_pc_i,
    output logic                      bk_ready_o,
    input  logic                      if3_redirect_i,
    input  logic [31:0]               if3_redirect_pc_i,
    input  logic [FETCH_WIDTH-1:0]    nlp_valid_i,
    input  logic [FETCH_WIDTH-1:0]    nlp_taken_i,
    input  logic [32*FETCH_WIDTH-1:0] nlp_target_i,
    output logic [31:0]               pc_o,
    output logic [31:0]               npc_o,
    output logic [FETCH_WIDTH-1:0]    fetch_mask_o,
    output logic                      ds_only_o
`ifdef IF0_PERF_CNT_EN
    ,
    output logic [31:0]               redirect_cnt_o,
    output logic [31:0]               ds_bubble_cnt_o
`endif
);

    localparam int unsigned SLOT_BITS   = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [31:0] GROUP_BYTES = 32'(FETCH_WIDTH * INST_BYTES);

    logic [31:0]          pc_q, pc_d;
    logic [31:0]          ds_target_q, ds_target_d;
    if0_state_e           state_q, state_d;

    logic [31:0]          group_base;
    logic [31:0]          group_next;
    logic [SLOT_BITS-1:0] slot_off;

    logic                 taken_hit;
    logic [SLOT_BITS-1:0] taken_k;
    logic [31:0]          taken_target;
    logic                 taken_last;

    // ------------------------------------------------------------------
    // Group alignment of the current PC
    // ------------------------------------------------------------------
    always_comb begin
        group_base = pc_q & ~(GROUP_BYTES - 32'd1);
        group_next = group_base + GROUP_BYTES;
        if (FETCH_WIDTH > 1) begin
            slot_off = pc_q[SLOT_BITS+1:2];
        end else begin
            slot_off = '0;
        end
    end

    // ------------------------------------------------------------------
    // First taken prediction at or above the entry slot
    // ------------------------------------------------------------------
    if0_first_taken #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_first_taken (
        .valid (nlp_valid_i),
        .taken (nlp_taken_i),
        .off   (slot_off),
        .hit   (taken_hit),
        .k     (taken_k)
    );

    always_comb begin
        taken_target = nlp_target_i[31:0];
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            if (int'(taken_k) == i) begin
                taken_target = nlp_target_i[32*i +: 32];
            end
        end
    end

    // Branch in the last slot: its delay slot lives in the next group.
    assign taken_last = (int'(taken_k) == int'(FETCH_WIDTH) - 1);

    // ------------------------------------------------------------------
    // Next-PC selection
    // ------------------------------------------------------------------
    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        ds_target_d = ds_target_q;

        if (flush_i) begin
            pc_d        = RESET_PC;
            state_d     = IF0_NORMAL;
            ds_target_d = '0;
        end else if (bk_redirect_valid_i) begin
            // Redirects win over pause and a pending delay slot; the
            // backend and IF3 never wait on fetch.
            pc_d    = bk_redirect_pc_i;
            state_d = IF0_NORMAL;
        end else if (if3_redirect_i) begin
            pc_d    = if3_redirect_pc_i;
            state_d = IF0_NORMAL;
        end else if (pause_i) begin
            // hold everything
        end else if (state_q == IF0_DS_PENDING) begin
            pc_d    = ds_target_q;
            state_d = IF0_NORMAL;
        end else if (taken_hit && !taken_last) begin
            pc_d = taken_target;
        end else if (taken_hit) begin
            pc_d        = group_next;
            ds_target_d = taken_target;
            state_d     = IF0_DS_PENDING;
        end else begin
            pc_d = group_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            state_q     <= IF0_NORMAL;
            ds_target_q <= '0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            ds_target_q <= ds_target_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        fetch_mask_o = '0;
        if (state_q == IF0_DS_PENDING) begin
            fetch_mask_o[0] = 1'b1;
        end else begin
            for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
                fetch_mask_o[i] = (i >= int'(slot_off));
            end
        end
    end

    assign pc_o       = pc_q;
    assign npc_o      = group_next;
    assign ds_only_o  = (state_q == IF0_DS_PENDING);
    assign bk_ready_o = 1'b1;

`ifdef IF0_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (saturating, cleared by rst only)
    // ------------------------------------------------------------------
    logic        sel_redirect;
    logic        sel_ds_jump;
    logic [31:0] redirect_cnt_q;
    logic [31:0] ds_bubble_cnt_q;

    assign sel_redirect = !flush_i && (bk_redirect_valid_i || if3_redirect_i);
    assign sel_ds_jump  = !flush_i && !bk_redirect_valid_i && !if3_redirect_i && !pause_i &&
                          (state_q == IF0_DS_PENDING);

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q  <= '0;
            ds_bubble_cnt_q <= '0;
        end else begin
            if (sel_redirect && (redirect_cnt_q != 32'hFFFFFFFF)) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
            if (sel_ds_jump && (ds_bubble_cnt_q != 32'hFFFFFFFF)) begin
                ds_bubble_cnt_q <= ds_bubble_cnt_q + 32'd1;
            end
        end
    end

    assign redirect_cnt_o  = redirect_cnt_q;
    assign ds_bubble_cnt_o = ds_bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if0_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_if0_pc_gen
// Self-checking bench for if0_pc_gen (FETCH_WIDTH=2, RESET_PC=BFC00000).
// A behavioural model of the fetch sequencing is compared against the DUT on
// every falling edge; directed scenarios add literal expectations, then a
// randomized phase exercises all selection priorities.
// -----------------------------------------------------------------------------
module tb_if0_pc_gen;

    localparam int unsigned W        = 2;
    localparam logic [31:0] RST_PC   = 32'hBFC00000;
    localparam longint unsigned GB   = W * 4;

    logic              clk;
    logic              rst;
    logic              flush_i;
    logic              pause_i;
    logic              bk_redirect_valid_i;
    logic [31:0]       bk_redirect_pc_i;
    logic              bk_ready_o;
    logic              if3_redirect_i;
    logic [31:0]       if3_redirect_pc_i;
    logic [W-1:0]      nlp_valid_i;
    logic [W-1:0]      nlp_taken_i;
    logic [32*W-1:0]   nlp_target_i;
    logic [31:0]       pc_o;
    logic [31:0]       npc_o;
    logic [W-1:0]      fetch_mask_o;
    logic              ds_only_o;
`ifdef IF0_PERF_CNT_EN
    logic [31:0]       redirect_cnt_o;
    logic [31:0]       ds_bubble_cnt_o;
`endif

    if0_pc_gen #(
        .FETCH_WIDTH (W),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush_i             (flush_i),
        .pause_i             (pause_i),
        .bk_redirect_valid_i (bk_redirect_valid_i),
        .bk_redirect_pc_i    (bk_redirect_pc_i),
        .bk_ready_o          (bk_ready_o),
        .if3_redirect_i      (if3_redirect_i),
        .if3_redirect_pc_i   (if3_redirect_pc_i),
        .nlp_valid_i         (nlp_valid_i),
        .nlp_taken_i         (nlp_taken_i),
        .nlp_target_i        (nlp_target_i),
        .pc_o                (pc_o),
        .npc_o               (npc_o),
        .fetch_mask_o        (fetch_mask_o),
        .ds_only_o           (ds_only_o)
`ifdef IF0_PERF_CNT_EN
        ,
        .redirect_cnt_o      (redirect_cnt_o),
        .ds_bubble_cnt_o     (ds_bubble_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: fetch PC, whether a delay-slot fetch is in
    // flight, and where to go after it.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic        ds;
        logic [31:0] dst;
        logic [31:0] n_redir;
        logic [31:0] n_bubble;
    } model_t;

    model_t m;

    function automatic logic [31:0] grp_next(input logic [31:0] pc);
        longint unsigned g;
        g = (longint'(pc) / GB + 1) * GB;
        return g[31:0];
    endfunction

    function automatic int unsigned entry_slot(input logic [31:0] pc);
        return int'((longint'(pc) % GB) / 4);
    endfunction

    function automatic logic [W-1:0] exp_mask(input model_t s);
        logic [W-1:0] r;
        r = '0;
        if (s.ds) begin
            r[0] = 1'b1;
        end else begin
            for (int i = 0; i < int'(W); i++) r[i] = (i >= int'(entry_slot(s.pc)));
        end
        return r;
    endfunction

    function automatic model_t model_next(input model_t s);
        model_t n;
        int     found;
        n = s;
        if (rst) begin
            n.pc = RST_PC; n.ds = 1'b0; n.dst = '0; n.n_redir = '0; n.n_bubble = '0;
        end else if (flush_i) begin
            n.pc = RST_PC; n.ds = 1'b0; n.dst = '0;
        end else if (bk_redirect_valid_i || if3_redirect_i) begin
            n.pc = bk_redirect_valid_i ? bk_redirect_pc_i : if3_redirect_pc_i;
            n.ds = 1'b0;
            if (s.n_redir != 32'hFFFFFFFF) n.n_redir = s.n_redir + 1;
        end else if (pause_i) begin
            n = s;
        end else if (s.ds) begin
            n.pc = s.dst; n.ds = 1'b0;
            if (s.n_bubble != 32'hFFFFFFFF) n.n_bubble = s.n_bubble + 1;
        end else begin
            found = -1;
            for (int i = int'(W) - 1; i >= int'(entry_slot(s.pc)); i--) begin
                if (nlp_valid_i[i] && nlp_taken_i[i]) found = i;
            end
            if (found < 0) begin
                n.pc = grp_next(s.pc);
            end else if (found < int'(W) - 1) begin
                n.pc = nlp_target_i[32*found +: 32];
            end else begin
                n.dst = nlp_target_i[32*found +: 32];
                n.ds  = 1'b1;
                n.pc  = grp_next(s.pc);
            end
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m);

    // Single compare process: outputs depend only on DUT state, so the
    // falling edge is a stable sampling point.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_o", pc_o, m.pc);
            chk("npc_o", npc_o, grp_next(m.pc));
            chk("fetch_mask_o", 32'(fetch_mask_o), 32'(exp_mask(m)));
            chk("ds_only_o", 32'(ds_only_o), 32'(m.ds));
            chk("bk_ready_o", 32'(bk_ready_o), 32'd1);
`ifdef IF0_PERF_CNT_EN
            chk("redirect_cnt_o", redirect_cnt_o, m.n_redir);
            chk("ds_bubble_cnt_o", ds_bubble_cnt_o, m.n_bubble);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; flush_i = 1'b0; pause_i = 1'b0;
        bk_redirect_valid_i = 1'b0; bk_redirect_pc_i = '0;
        if3_redirect_i = 1'b0; if3_redirect_pc_i = '0;
        nlp_valid_i = '0; nlp_taken_i = '0; nlp_target_i = '0;
    endtask

    task automatic go_to(input logic [31:0] pc);
        idle();
        bk_redirect_valid_i = 1'b1;
        bk_redirect_pc_i    = pc;
        cyc();
        idle();
    endtask

    task automatic predict(input logic [W-1:0] v, input logic [W-1:0] t,
                           input logic [31:0] t0, input logic [31:0] t1);
        nlp_valid_i  = v;
        nlp_taken_i  = t;
        nlp_target_i = {t1, t0};
    endtask

    initial begin
        logic [31:0] r;
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk_en = 1'b1;

        // 1. Reset state, then a sequential step
        chk("rst_pc", pc_o, 32'hBFC00000);
        chk("rst_mask", 32'(fetch_mask_o), 32'h3);
        chk("rst_ds_only", 32'(ds_only_o), 32'h0);
        chk("rst_npc", npc_o, 32'hBFC00008);
        chk("model_rst_pc", m.pc, 32'hBFC00000);
        cyc();
        chk("seq_pc", pc_o, 32'hBFC00008);

        // 2. Slot 0 taken, delay slot in the same group
        go_to(32'h1000);
        predict(2'b01, 2'b01, 32'h2000, 32'h5555_0000);
        cyc();
        idle();
        chk("s0_taken_pc", pc_o, 32'h2000);
        chk("s0_taken_mask", 32'(fetch_mask_o), 32'h3);
        chk("s0_taken_ds", 32'(ds_only_o), 32'h0);

        // 3. Slot 1 taken: delay-slot-only fetch, then target
        go_to(32'h1000);
        predict(2'b10, 2'b10, 32'h5555_0000, 32'h3000);
        cyc();
        chk("s1_taken_pc", pc_o, 32'h1008);
        chk("s1_taken_ds", 32'(ds_only_o), 32'h1);
        chk("s1_taken_mask", 32'(fetch_mask_o), 32'h1);
        chk("model_ds", 32'(m.ds), 32'h1);
        predict(2'b01, 2'b01, 32'h7000, 32'h0);   // must be ignored
        cyc();
        idle();
        chk("ds_target_pc", pc_o, 32'h3000);
        chk("ds_target_ds", 32'(ds_only_o), 32'h0);

        // 4. Mid-group entry ignores predictions below the entry slot
        go_to(32'h1004);
        chk("mid_mask", 32'(fetch_mask_o), 32'h2);
        predict(2'b11, 2'b01, 32'h6000, 32'h6100);
        cyc();
        idle();
        chk("mid_pc", pc_o, 32'h1008);

        // 5. Redirects override a pending delay slot; backend beats IF3
        go_to(32'h1000);
        predict(2'b10, 2'b10, 32'h0, 32'h3000);
        cyc();
        idle();
        bk_redirect_valid_i = 1'b1; bk_redirect_pc_i = 32'h8000;
        if3_redirect_i = 1'b1; if3_redirect_pc_i = 32'h9000;
        cyc();
        idle();
        chk("ovr_pc", pc_o, 32'h8000);
        chk("ovr_ds", 32'(ds_only_o), 32'h0);
        cyc();
        chk("ovr_next_pc", pc_o, 32'h8008);

        // 6. Pause holds; redirect beats pause; flush reloads reset PC
        go_to(32'h1000);
        pause_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pause_pc", pc_o, 32'h1000);
        end
        if3_redirect_i = 1'b1; if3_redirect_pc_i = 32'h4000;
        cyc();
        idle();
        chk("pause_if3_pc", pc_o, 32'h4000);
        flush_i = 1'b1;
        cyc();
        idle();
        chk("flush_pc", pc_o, 32'hBFC00000);

        // Address wrap and a misaligned redirect target
        go_to(32'hFFFFFFFC);
        chk("wrap_mask", 32'(fetch_mask_o), 32'h2);
        chk("wrap_npc", npc_o, 32'h0);
        cyc();
        chk("wrap_pc", pc_o, 32'h0);
        go_to(32'h1006);
        chk("misalign_pc", pc_o, 32'h1006);
        cyc();
        chk("misalign_next", pc_o, 32'h1008);

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            rst                 = ($urandom_range(0, 199) == 0);
            flush_i             = ($urandom_range(0, 99) < 2);
            pause_i             = ($urandom_range(0, 99) < 15);
            bk_redirect_valid_i = ($urandom_range(0, 99) < 5);
            if3_redirect_i      = ($urandom_range(0, 99) < 5);
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            bk_redirect_pc_i = r;
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            if3_redirect_pc_i = r;
            nlp_valid_i  = W'($urandom);
            nlp_taken_i  = W'($urandom);
            nlp_target_i = {$urandom, $urandom};
            cyc();
        end

        idle();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
